// File: rtl/ecg_frame_window.sv
// ecg_frame_window: collects 4-channel frames into a WINDOW-long buffer and streams them out, mean-removed and saturated.
// Optional centring (accumulators, mean registers, MEAN state) is enabled by defining ECG_FRAME_CENTER_EN; otherwise raw samples stream out.
module ecg_frame_window #(
  parameter int WIDTH = 32,
  parameter int WINDOW = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [4*WIDTH-1:0]           in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4*WIDTH-1:0]           out_data,
  output logic [$clog2(WINDOW)-1:0]    out_index,
  output logic                         out_last,
  output logic                         busy,
  output logic                         overrun
);
  localparam int LW = $clog2(WINDOW);
`ifdef ECG_FRAME_CENTER_EN
  typedef enum logic [1:0] {FILL, MEAN, DRAIN} state_t;
`else
  typedef enum logic [1:0] {FILL, DRAIN} state_t;
`endif
  state_t state;
  logic [4*WIDTH-1:0] mem [WINDOW];
  logic [LW-1:0] wr_ptr, rd_ptr;
  logic [4*WIDTH-1:0] rd_frame, cen;
  logic accept, load, done;
  assign accept = in_valid && state == FILL;
  assign done = out_valid && out_ready && out_last;
  // rd_ptr is a fetch pointer: the next sample is loaded whenever the output register is free or draining
  assign load = state == DRAIN && (!out_valid || out_ready) && !(out_valid && out_last);
  assign busy = state != FILL;
  assign rd_frame = mem[rd_ptr];
  always_ff @(posedge clk)
    if (accept) mem[wr_ptr] <= in_data;
`ifdef ECG_FRAME_CENTER_EN
  logic signed [WIDTH+LW-1:0] acc [4];
  logic signed [WIDTH-1:0] mean [4];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int c = 0; c < 4; c++) begin
        acc[c] <= '0;
        mean[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (done) acc[c] <= '0;
        else if (accept) acc[c] <= acc[c] + {{LW{in_data[c*WIDTH+WIDTH-1]}}, in_data[c*WIDTH+:WIDTH]};
        if (state == MEAN) mean[c] <= WIDTH'(acc[c] >>> LW);
      end
    end
  // difference at WIDTH+1 bits; overflow when the top two bits disagree
  always_comb begin
    logic [WIDTH:0] d;
    cen = '0;
    for (int c = 0; c < 4; c++) begin
      d = {rd_frame[c*WIDTH+WIDTH-1], rd_frame[c*WIDTH+:WIDTH]} - {mean[c][WIDTH-1], mean[c]};
      cen[c*WIDTH+:WIDTH] = d[WIDTH] != d[WIDTH-1] ? {d[WIDTH], {(WIDTH-1){~d[WIDTH]}}} : d[WIDTH-1:0];
    end
  end
`else
  assign cen = rd_frame;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= FILL;
      wr_ptr <= '0;
      rd_ptr <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_index <= '0;
      out_last <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (in_valid && state != FILL) overrun <= 1'b1;
      if (load) begin
        out_valid <= 1'b1;
        out_data <= cen;
        out_index <= rd_ptr;
        out_last <= &rd_ptr;
        rd_ptr <= rd_ptr + 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last <= 1'b0;
      end
      if (state == FILL && accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (&wr_ptr) begin
          rd_ptr <= '0;
`ifdef ECG_FRAME_CENTER_EN
          state <= MEAN;
`else
          state <= DRAIN;
`endif
        end
      end
`ifdef ECG_FRAME_CENTER_EN
      else if (state == MEAN) begin
        rd_ptr <= '0;
        state <= DRAIN;
      end
`endif
      else if (state == DRAIN && done) begin
        wr_ptr <= '0;
        state <= FILL;
      end
    end
endmodule

// File: tb/tb_ecg_frame_window.sv
// tb_ecg_frame_window: randomized and directed stimulus checked every cycle against a window-level reference model.
module tb_ecg_frame_window;
`ifdef ECG_FRAME_CENTER_EN
  localparam bit CEN = 1'b1;
`else
  localparam bit CEN = 1'b0;
`endif
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;
  logic clk = 1'b0, reset, in_valid, out_ready, out_valid, out_last, busy, overrun;
  logic [127:0] in_data, out_data;
  logic [1:0] out_index;
  int tests = 0, fails = 0;
  typedef struct {logic [127:0] d; int idx; bit last;} exp_t;
  exp_t outq[$];
  logic [127:0] fr[$];
  bit fill = 1'b1, ev = 1'b0, ovr = 1'b0;
  int delay = 0;
  logic [31:0] ch1v [4], ch2v [4];

  ecg_frame_window #(.WIDTH(32), .WINDOW(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic longint sx(input logic [127:0] f, input int c);
    return longint'($signed(f[c*32+:32]));
  endfunction

  // expected output of sample i: sample minus floor(mean), clamped to the 32-bit signed range
  function automatic longint centre(input longint s0, s1, s2, s3, input int i);
    longint s [4];
    longint sum, m, v;
    s = '{s0, s1, s2, s3};
    sum = s0 + s1 + s2 + s3;
    m = 0;
    if (CEN) begin
      m = sum / 4;
      if (sum < 0 && sum % 4 != 0) m = m - 1;
    end
    v = s[i] - m;
    if (v > MAXV) v = MAXV;
    if (v < MINV) v = MINV;
    return v;
  endfunction

  always @(negedge clk) begin : model
    bit f0, v0;
    exp_t e;
    logic [127:0] d;
    if (reset) begin
      chk("reset_state", |{out_valid, out_last, busy, overrun, out_index, out_data}, 0);
      outq.delete();
      fr.delete();
      fill = 1'b1;
      ev = 1'b0;
      ovr = 1'b0;
      delay = 0;
    end else begin
      chk("out_valid", out_valid, ev);
      chk("busy", busy, !fill);
      chk("overrun", overrun, ovr);
      if (ev && outq.size() > 0) begin
        chk("out_data", out_data, outq[0].d);
        chk("out_index", out_index, outq[0].idx);
        chk("out_last", out_last, outq[0].last);
      end
      f0 = fill;
      v0 = ev;
      if (v0 && out_ready) begin
        e = outq.pop_front();
        if (e.last) begin
          fill = 1'b1;
          ev = 1'b0;
        end
      end
      if (delay > 0) begin
        delay--;
        if (delay == 0) ev = 1'b1;
      end
      if (in_valid) begin
        if (f0) begin
          fr.push_back(in_data);
          if (fr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
              d = '0;
              for (int c = 0; c < 4; c++)
                d[c*32+:32] = 32'(centre(sx(fr[0], c), sx(fr[1], c), sx(fr[2], c), sx(fr[3], c), i));
              outq.push_back('{d, i, i == 3});
            end
            fr.delete();
            fill = 1'b0;
            delay = CEN ? 2 : 1;
          end
        end else ovr = 1'b1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] f);
    in_data = f;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
  endtask

  function automatic logic [127:0] frame(input int k);
    return {$urandom, ch2v[k], ch1v[k], 32'(10 * (k + 1))};
  endfunction

  function automatic logic [31:0] rsamp;
    case ($urandom_range(0, 3))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_idle(input string n);
    int k = 0;
    while (!(fill && outq.size() == 0) && k < 100) begin
      tick;
      k++;
    end
    if (k >= 100) begin
      tests++;
      fails++;
      $display("FAIL %s: window not drained after %0d cycles, required within 100", n, k);
    end
  endtask

  task automatic wait_valid(input string n);
    int k = 0;
    while (!ev && k < 20) begin
      tick;
      k++;
    end
    if (k >= 20) begin
      tests++;
      fails++;
      $display("FAIL %s: no output after %0d cycles, required within 20", n, k);
    end
  endtask

  initial begin
    ch1v = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE};
    ch2v = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000000};
    chk("pin_basic0", centre(10, 20, 30, 40, 0), CEN ? -15 : 10);
    chk("pin_basic3", centre(10, 20, 30, 40, 3), CEN ? 15 : 40);
    chk("pin_round0", centre(-1, -2, -2, -2, 0), CEN ? 1 : -1);
    chk("pin_round1", centre(-1, -2, -2, -2, 1), CEN ? 0 : -2);
    chk("pin_sat0", centre(MAXV, MAXV, MINV, MINV, 0), MAXV);
    chk("pin_sat2", centre(MAXV, MAXV, MINV, MINV, 2), CEN ? MINV + 1 : MINV);
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    tick;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) send(frame(k));
    wait_idle("win_basic");
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(frame(k));
    send({4{$urandom}});
    wait_valid("win_stall");
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    repeat (2) tick;
    send({4{$urandom}});
    repeat (2) tick;
    for (int k = 0; k < 8; k++) begin
      out_ready = !out_ready;
      tick;
    end
    out_ready = 1'b1;
    wait_idle("win_stall");
    chk("overrun_sticky", overrun, 1);
    send(frame(0));
    send(frame(1));
    #2 reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    tick;
    chk("overrun_cleared", overrun, 0);
    for (int k = 0; k < 4; k++) send({rsamp(), rsamp(), rsamp(), rsamp()});
    wait_idle("win_reset");
    for (int k = 0; k < 400; k++) begin
      in_valid = $urandom_range(0, 2) == 0;
      in_data = {rsamp(), rsamp(), rsamp(), rsamp()};
      out_ready = $urandom_range(0, 3) != 0;
      tick;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle("random");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
